return_stack: RTL and testbench

Hardware return-address stack for the RAT CPU, the producer side of the program counter mux's stack input. It pushes PC+1 on CALL or interrupt entry and pops on RET/RETIE. Its top entry drives FROM_STACK combinationally, so the PC loads the return address on the same edge that retires the pop. Overflow and underflow are caught and reported as sticky flags to the control unit.

---
 rtl/rat_pkg.sv | 17 +
 rtl/return_stack_if.sv | 32 +++
 rtl/return_stack.sv | 93 +++++++++
 tb/tb_return_stack.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/rat_pkg.sv
// Shared RAT CPU definitions: program address width, interrupt vector and
// the PC-mux select encoding used by the control unit.
package rat_pkg;

    localparam int unsigned PC_W = 10;

    typedef logic [PC_W-1:0] pc_t;

    localparam pc_t INTR_VECTOR = 10'h3FF;

    typedef enum logic [1:0] {
        SEL_IMMED = 2'd0,
        SEL_STACK = 2'd1,
        SEL_INTR  = 2'd2
    } pc_sel_e;

endpackage

// File: rtl/return_stack_if.sv
// Control-unit <-> return-stack signal bundle. The control unit is the
// master and the stack is the slave.
interface return_stack_if
    import rat_pkg::*;
#(
    parameter int unsigned DEPTH = 32
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic             PUSH;
    logic             POP;
    pc_t              PUSH_DATA;
    logic             FLUSH;
    logic             CLR_ERR;
    pc_t              FROM_STACK;
    logic             EMPTY;
    logic             FULL;
    logic [CNT_W-1:0] COUNT;
    logic             OVERFLOW;
    logic             UNDERFLOW;

    modport master (
        output PUSH, POP, PUSH_DATA, FLUSH, CLR_ERR,
        input  FROM_STACK, EMPTY, FULL, COUNT, OVERFLOW, UNDERFLOW
    );

    modport slave (
        input  PUSH, POP, PUSH_DATA, FLUSH, CLR_ERR,
        output FROM_STACK, EMPTY, FULL, COUNT, OVERFLOW, UNDERFLOW
    );

endinterface

// File: rtl/return_stack.sv
// Return-address stack feeding the PC mux. The top entry is a pure register
// read so the PC can capture it on the same edge that retires a pop.
module return_stack
    import rat_pkg::*;
#(
    parameter int unsigned DEPTH = 32
)(
    input  logic           CLK,
    input  logic           RST_N,
    return_stack_if.slave  bus
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned CNT_W = AW + 1;

    pc_t              mem_q [DEPTH];
    pc_t              mem_d [DEPTH];
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;

    logic             empty, full;
    logic [AW-1:0]    top_idx, wr_idx;

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == CNT_W'(DEPTH));
    assign top_idx = AW'(cnt_q - CNT_W'(1));
    assign wr_idx  = cnt_q[AW-1:0];

    always_comb begin
        mem_d = mem_q;
        cnt_d = cnt_q;
        // Clear first so a same-cycle error event below re-sets the flag.
        ovf_d = ovf_q & ~bus.CLR_ERR;
        udf_d = udf_q & ~bus.CLR_ERR;

        if (bus.FLUSH) begin
            cnt_d = '0;
        end else begin
            unique case ({bus.PUSH, bus.POP})
                2'b10: begin
                    if (full) begin
                        ovf_d = 1'b1;
                    end else begin
                        mem_d[wr_idx] = bus.PUSH_DATA;
                        cnt_d         = cnt_q + CNT_W'(1);
                    end
                end
                2'b01: begin
                    if (empty) begin
                        udf_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                2'b11: begin
                    // Simultaneous call/return: replace the top in place, or
                    // act as a plain push (flagging the bad pop) when empty.
                    if (empty) begin
                        mem_d[0] = bus.PUSH_DATA;
                        cnt_d    = CNT_W'(1);
                        udf_d    = 1'b1;
                    end else begin
                        mem_d[top_idx] = bus.PUSH_DATA;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            mem_q <= '{default: '0};
            cnt_q <= '0;
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            mem_q <= mem_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            udf_q <= udf_d;
        end
    end

    assign bus.FROM_STACK = empty ? '0 : mem_q[top_idx];
    assign bus.EMPTY      = empty;
    assign bus.FULL       = full;
    assign bus.COUNT      = cnt_q;
    assign bus.OVERFLOW   = ovf_q;
    assign bus.UNDERFLOW  = udf_q;

endmodule

// File: tb/tb_return_stack.sv
// Scoreboard bench for return_stack: expected pop values are queued at drive
// time and compared while POP is asserted; state is compared after each edge.
module tb_return_stack;
    import rat_pkg::*;

    localparam int unsigned DEPTH = 32;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    return_stack_if #(.DEPTH(DEPTH)) bus ();

    return_stack #(.DEPTH(DEPTH)) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .bus   (bus.slave)
    );

    int unsigned checks   = 0;
    int unsigned failures = 0;

    pc_t         exp_q[$];
    pc_t         m_mem [DEPTH];
    int unsigned m_cnt;
    logic        m_ovf, m_udf;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic pc_t model_top();
        return (m_cnt == 0) ? pc_t'(0) : m_mem[m_cnt-1];
    endfunction

    task automatic model_reset();
        for (int unsigned i = 0; i < DEPTH; i++) m_mem[i] = '0;
        m_cnt = 0;
        m_ovf = 1'b0;
        m_udf = 1'b0;
    endtask

    task automatic model_step(input logic p, input logic o, input pc_t d,
                              input logic f, input logic c);
        if (c) begin
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end
        if (f) begin
            m_cnt = 0;
        end else if (p && !o) begin
            if (m_cnt == DEPTH) m_ovf = 1'b1;
            else begin
                m_mem[m_cnt] = d;
                m_cnt++;
            end
        end else if (o && !p) begin
            if (m_cnt == 0) m_udf = 1'b1;
            else m_cnt--;
        end else if (p && o) begin
            if (m_cnt == 0) begin
                m_mem[0] = d;
                m_cnt    = 1;
                m_udf    = 1'b1;
            end else begin
                m_mem[m_cnt-1] = d;
            end
        end
    endtask

    task automatic post_check();
        check("count",      bus.COUNT,      m_cnt);
        check("empty",      bus.EMPTY,      (m_cnt == 0) ? 1 : 0);
        check("full",       bus.FULL,       (m_cnt == DEPTH) ? 1 : 0);
        check("overflow",   bus.OVERFLOW,   m_ovf);
        check("underflow",  bus.UNDERFLOW,  m_udf);
        check("from_stack", bus.FROM_STACK, model_top());
    endtask

    // Called at posedge+2; returns at the following posedge+2.
    task automatic drive(input logic p, input logic o, input pc_t d,
                         input logic f, input logic c);
        bus.PUSH      = p;
        bus.POP       = o;
        bus.PUSH_DATA = d;
        bus.FLUSH     = f;
        bus.CLR_ERR   = c;
        if (o) exp_q.push_back(model_top());
        model_step(p, o, d, f, c);
        @(posedge clk);
        #1;
        post_check();
        #1;
        bus.PUSH    = 1'b0;
        bus.POP     = 1'b0;
        bus.FLUSH   = 1'b0;
        bus.CLR_ERR = 1'b0;
    endtask

    // Pop monitor: the stack output is combinational from state, so the
    // value is checked mid-cycle, before the edge that retires the pop.
    always @(negedge clk) begin
        if (rst_n && bus.POP) begin
            check("sb_pending", exp_q.size(), 1);
            if (exp_q.size() > 0) check("pop_value", bus.FROM_STACK, exp_q.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n         = 1'b0;
        bus.PUSH      = 1'b0;
        bus.POP       = 1'b0;
        bus.PUSH_DATA = '0;
        bus.FLUSH     = 1'b0;
        bus.CLR_ERR   = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_from_stack", bus.FROM_STACK, 0);
        check("rst_empty",      bus.EMPTY,      1);
        check("rst_count",      bus.COUNT,      0);
        check("rst_full",       bus.FULL,       0);
        #1;
        rst_n = 1'b1;

        // LIFO order
        drive(1, 0, 10'h010, 0, 0);
        drive(1, 0, 10'h020, 0, 0);
        drive(1, 0, 10'h030, 0, 0);
        for (int i = 0; i < 3; i++) drive(0, 1, '0, 0, 0);
        check("lifo_empty", bus.EMPTY, 1);
        check("lifo_top0",  bus.FROM_STACK, 0);

        // Fill then overflow
        for (int unsigned i = 0; i < DEPTH; i++) drive(1, 0, pc_t'(10'h100 + i), 0, 0);
        drive(1, 0, 10'h3AA, 0, 0);
        check("ovf_full",  bus.FULL, 1);
        check("ovf_count", bus.COUNT, 32);
        check("ovf_flag",  bus.OVERFLOW, 1);
        check("ovf_top",   bus.FROM_STACK, 10'h11F);

        // Replace at FULL must not raise overflow
        drive(0, 0, '0, 0, 1);
        drive(1, 1, 10'h155, 0, 0);
        check("rep_full_ovf", bus.OVERFLOW, 0);
        check("rep_full_top", bus.FROM_STACK, 10'h155);

        // Replace with COUNT=2
        drive(0, 0, '0, 1, 0);
        drive(1, 0, 10'h123, 0, 0);
        drive(1, 0, 10'h045, 0, 0);
        drive(1, 1, 10'h2B0, 0, 0);
        check("rep_top",   bus.FROM_STACK, 10'h2B0);
        check("rep_count", bus.COUNT, 2);
        check("rep_udf",   bus.UNDERFLOW, 0);
        drive(0, 1, '0, 0, 0);
        drive(0, 1, '0, 0, 0);

        // Underflow and CLR_ERR priority
        drive(0, 1, '0, 0, 0);
        check("udf_set",   bus.UNDERFLOW, 1);
        check("udf_count", bus.COUNT, 0);
        drive(0, 1, '0, 0, 1);
        check("udf_clr_and_set", bus.UNDERFLOW, 1);
        drive(0, 0, '0, 0, 1);
        check("udf_clr", bus.UNDERFLOW, 0);

        // PUSH & POP while empty acts as push and flags underflow
        drive(1, 1, 10'h077, 0, 0);
        check("pp_empty_count", bus.COUNT, 1);
        check("pp_empty_udf",   bus.UNDERFLOW, 1);
        check("pp_empty_top",   bus.FROM_STACK, 10'h077);
        drive(0, 0, '0, 1, 1);

        // FLUSH beats PUSH
        for (int unsigned i = 0; i < 5; i++) drive(1, 0, pc_t'(10'h050 + i), 0, 0);
        drive(1, 0, 10'h3FF, 1, 0);
        check("flush_count", bus.COUNT, 0);
        check("flush_empty", bus.EMPTY, 1);
        check("flush_top",   bus.FROM_STACK, 0);

        // Asynchronous reset mid-cycle with stale contents and a set flag
        drive(0, 1, '0, 0, 0);
        drive(1, 0, 10'h1C1, 0, 0);
        drive(1, 0, 10'h1C2, 0, 0);
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("arst_from_stack", bus.FROM_STACK, 0);
        check("arst_empty",      bus.EMPTY, 1);
        check("arst_count",      bus.COUNT, 0);
        check("arst_ovf",        bus.OVERFLOW, 0);
        check("arst_udf",        bus.UNDERFLOW, 0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        drive(1, 0, 10'h2E2, 0, 0);
        drive(0, 1, '0, 0, 0);

        check("sb_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
